// File: rtl/input_load_sched_if.sv
// Bus bundle for input_load_sched: load control, external word stream,
// core read port and the single-port input SRAM side.
interface input_load_sched_if #(
   parameter int IN_W = 16,
   parameter int DW   = 32,
   parameter int AW   = 7
);
   // ext stream: a word moves only in a cycle where ext_valid and ext_ready
   // are both high at the rising edge; ext_valid may wait without limit.
   logic            start;
   logic [AW-1:0]   start_addr;
   logic [AW:0]     len;
   logic            ext_valid;
   logic            ext_ready;
   logic [IN_W-1:0] ext_in;
   logic            rd_req;
   logic [AW-1:0]   rd_addr;
   logic            rd_gnt;
   logic [AW-1:0]   sram_addr;
   logic [DW-1:0]   sram_din;
   logic            sram_wr_en;
   logic            sram_rd_en;
   logic            busy;
   logic            done;
   logic [2:0]      state_dbg;

   modport slave (
      input  start, start_addr, len, ext_valid, ext_in, rd_req, rd_addr,
      output ext_ready, rd_gnt, sram_addr, sram_din, sram_wr_en, sram_rd_en,
             busy, done, state_dbg
   );

   modport master (
      output start, start_addr, len, ext_valid, ext_in, rd_req, rd_addr,
      input  ext_ready, rd_gnt, sram_addr, sram_din, sram_wr_en, sram_rd_en,
             busy, done, state_dbg
   );
endinterface

// File: rtl/input_load_sched.sv
// Packs pairs of external 16-bit words into 32-bit input SRAM writes and
// shares the single SRAM port with core reads, which always take priority.
module input_load_sched #(
   parameter int IN_W  = 16,
   parameter int DW    = 32,
   parameter int AW    = 7,
   parameter int DEPTH = 128
) (
   input logic                clk,
   input logic                rst,
   input_load_sched_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_LO = 3'd1,
      LOAD_HI = 3'd2,
      WRITE   = 3'd3,
      FIN     = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [IN_W-1:0] lo_q, lo_d;
   logic [DW-1:0]   word_q, word_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [AW:0]     remaining_q, remaining_d;
   logic [AW-1:0]   sram_addr_q, sram_addr_d;
   logic [DW-1:0]   sram_din_q, sram_din_d;
   logic            wr_en_q, wr_en_d;
   logic            rd_en_q, rd_en_d;
   logic            done_q, done_d;
   logic            ext_hs;

   assign bus.ext_ready  = (state_q == LOAD_LO) || (state_q == LOAD_HI);
   assign ext_hs         = bus.ext_valid && bus.ext_ready;
   assign bus.rd_gnt     = bus.rd_req && rst;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = done_q;
   assign bus.sram_addr  = sram_addr_q;
   assign bus.sram_din   = sram_din_q;
   assign bus.sram_wr_en = wr_en_q;
   assign bus.sram_rd_en = rd_en_q;
   assign bus.state_dbg  = state_q;

   always_comb begin
      state_d     = state_q;
      lo_d        = lo_q;
      word_d      = word_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      sram_addr_d = sram_addr_q;
      sram_din_d  = sram_din_q;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      done_d      = 1'b0;

      // A read owns the port this cycle; WRITE below sees rd_req and stalls.
      if (bus.rd_req) begin
         rd_en_d     = 1'b1;
         sram_addr_d = bus.rd_addr;
      end

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               addr_d      = bus.start_addr;
               remaining_d = bus.len;
               state_d     = (bus.len == '0) ? FIN : LOAD_LO;
            end
         end
         LOAD_LO: begin
            if (ext_hs) begin
               lo_d    = bus.ext_in;
               state_d = LOAD_HI;
            end
         end
         LOAD_HI: begin
            if (ext_hs) begin
               word_d  = {bus.ext_in, lo_q};
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (!bus.rd_req) begin
               wr_en_d     = 1'b1;
               sram_addr_d = addr_q;
               sram_din_d  = word_q;
               addr_d      = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               state_d     = (remaining_q == (AW+1)'(1)) ? FIN : LOAD_LO;
            end
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         lo_q        <= '0;
         word_q      <= '0;
         addr_q      <= '0;
         remaining_q <= '0;
         sram_addr_q <= '0;
         sram_din_q  <= '0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lo_q        <= lo_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         sram_addr_q <= sram_addr_d;
         sram_din_q  <= sram_din_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_input_load_sched.sv
// Bench for input_load_sched: event-level model of loads, packing, read
// priority and done/busy timing, compared against the DUT every cycle.
module tb_input_load_sched;

   logic        clk;
   logic        rst;
   logic        chk_en;
   logic        start;
   logic [6:0]  start_addr;
   logic [7:0]  len;
   logic        ext_valid;
   logic [15:0] ext_in;
   logic        rd_req;
   logic [6:0]  rd_addr;

   logic        ext_ready, rd_gnt, sram_wr_en, sram_rd_en, busy, done;
   logic [6:0]  sram_addr;
   logic [31:0] sram_din;

   input_load_sched_if bus_if ();

   assign bus_if.start      = start;
   assign bus_if.start_addr = start_addr;
   assign bus_if.len        = len;
   assign bus_if.ext_valid  = ext_valid;
   assign bus_if.ext_in     = ext_in;
   assign bus_if.rd_req     = rd_req;
   assign bus_if.rd_addr    = rd_addr;
   assign ext_ready  = bus_if.ext_ready;
   assign rd_gnt     = bus_if.rd_gnt;
   assign sram_addr  = bus_if.sram_addr;
   assign sram_din   = bus_if.sram_din;
   assign sram_wr_en = bus_if.sram_wr_en;
   assign sram_rd_en = bus_if.sram_rd_en;
   assign busy       = bus_if.busy;
   assign done       = bus_if.done;

   input_load_sched dut (.clk(clk), .rst(rst), .bus(bus_if));

   int errors = 0;
   int checks = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // ext stream driver
   logic [15:0] src_q[$];
   bit          vpat_q[$];
   int          vmode = 0;

   initial begin
      ext_valid = 1'b0;
      ext_in    = '0;
      forever begin
         @(negedge clk);
         if (ext_valid && ext_ready && src_q.size() > 0) void'(src_q.pop_front());
         @(posedge clk);
         #2;
         if (!rst) begin
            src_q.delete();
            vpat_q.delete();
            ext_valid = 1'b0;
         end else if (src_q.size() > 0) begin
            ext_in = src_q[0];
            case (vmode)
               0:       ext_valid = 1'b1;
               1:       ext_valid = ($urandom_range(0, 1) == 1);
               default: ext_valid = (vpat_q.size() > 0) ? vpat_q.pop_front() : 1'b1;
            endcase
         end else begin
            ext_valid = 1'b0;
            ext_in    = 16'($urandom);
         end
      end
   end

   // model + scoreboard
   typedef struct packed {
      logic [6:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_q[$];
   logic        m_busy, m_done_now, m_fin_next, m_wr_due, m_rd_prev;
   logic [6:0]  m_rd_addr_prev, m_last_addr;
   logic [15:0] m_lo;
   int          m_pending, m_hs, m_len, m_sa, m_wr_done;
   logic [31:0] mem_img [128];
   int          wr_cnt = 0, done_cnt = 0, rd5_cnt = 0;

   initial begin
      wr_t        e;
      logic       exp_wr, exp_rd, exp_rdy, cur_fin, acc;
      logic [6:0] exp_addr;
      for (int i = 0; i < 128; i++) mem_img[i] = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst || !chk_en) begin
            m_busy = 0; m_done_now = 0; m_fin_next = 0; m_wr_due = 0; m_rd_prev = 0;
            m_rd_addr_prev = 0; m_last_addr = 0; m_lo = 0;
            m_pending = 0; m_hs = 0; m_len = 0; m_sa = 0; m_wr_done = 0;
            exp_q.delete();
         end else begin
            exp_wr   = m_wr_due;
            exp_rd   = m_rd_prev;
            cur_fin  = m_fin_next;
            exp_addr = m_last_addr;
            chk("sram_wr_en", sram_wr_en, exp_wr);
            chk("sram_rd_en", sram_rd_en, exp_rd);
            chk("strobe_excl", sram_wr_en & sram_rd_en, 1'b0);
            if (exp_wr) begin
               e        = exp_q.pop_front();
               exp_addr = e.a;
               chk("sram_din", sram_din, e.d);
               m_pending--;
               m_wr_done++;
               if (m_wr_done == m_len) cur_fin = 1;
            end else if (exp_rd) begin
               exp_addr = m_rd_addr_prev;
            end
            chk("sram_addr", sram_addr, exp_addr);
            m_last_addr = exp_addr;
            chk("done", done, m_done_now);
            chk("busy", busy, m_busy);
            chk("rd_gnt", rd_gnt, rd_req);
            exp_rdy = m_busy && (m_pending == 0) && (m_hs < 2 * m_len);
            chk("ext_ready", ext_ready, exp_rdy);

            if (sram_wr_en) begin
               mem_img[sram_addr] = sram_din;
               wr_cnt++;
            end
            if (sram_rd_en && sram_addr == 7'd5) rd5_cnt++;
            if (done) done_cnt++;

            // A packed word waits one cycle in WRITE, then goes out unless a read is asked.
            m_wr_due = (m_pending > 0) && !rd_req;
            if (ext_valid && exp_rdy) begin
               if (m_hs % 2 == 0) m_lo = ext_in;
               else begin
                  e.a = 7'((m_sa + m_hs / 2) % 128);
                  e.d = {ext_in, m_lo};
                  exp_q.push_back(e);
                  m_pending++;
               end
               m_hs++;
            end
            acc        = start && !m_busy;
            m_done_now = cur_fin;
            m_fin_next = acc && (len == 0);
            if (acc) begin
               m_sa = int'(start_addr); m_len = int'(len); m_hs = 0; m_wr_done = 0; m_busy = 1;
            end
            if (cur_fin) m_busy = 0;
            m_rd_prev      = rd_req;
            m_rd_addr_prev = rd_addr;
         end
      end
   end

   // driver tasks
   task automatic do_start(input logic [6:0] sa, input logic [7:0] l);
      @(posedge clk);
      #1;
      start = 1'b1; start_addr = sa; len = l;
      @(posedge clk);
      #1;
      start = 1'b0; start_addr = 7'($urandom); len = 8'($urandom);
   endtask

   task automatic wait_idle(input int budget, input bit rnd);
      int n = 0;
      forever begin
         @(posedge clk);
         if (!m_busy) break;
         if (n++ >= budget) begin
            errors++; checks++;
            $display("FAIL wait_idle: load still busy after %0d cycles", budget);
            break;
         end
         #1;
         if (rnd) begin
            rd_req  = ($urandom_range(0, 3) == 0);
            rd_addr = 7'($urandom);
            start   = (m_hs < 2 * m_len) && ($urandom_range(0, 7) == 0);
            start_addr = 7'($urandom);
            len     = 8'($urandom_range(0, 128));
         end
      end
      #1;
      rd_req = 1'b0; start = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ext_ready"}, ext_ready, 1'b0);
      chk({tag, "_rd_gnt"}, rd_gnt, 1'b0);
      chk({tag, "_sram_addr"}, sram_addr, 7'd0);
      chk({tag, "_sram_din"}, sram_din, 32'd0);
      chk({tag, "_wr_en"}, sram_wr_en, 1'b0);
      chk({tag, "_rd_en"}, sram_rd_en, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
   endtask

   // main sequence
   initial begin
      int wr0, dn0, rd0, n;
      logic [6:0] sa;
      int l;
      chk_en = 1'b0; rst = 1'b1;
      start = 1'b0; start_addr = '0; len = '0; rd_req = 1'b0; rd_addr = '0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst = 1'b1; chk_en = 1'b1;

      // basic load
      vmode = 0;
      dn0 = done_cnt;
      src_q.push_back(16'h1111); src_q.push_back(16'h2222);
      src_q.push_back(16'h3333); src_q.push_back(16'h4444);
      do_start(7'd0, 8'd2);
      wait_idle(200, 0);
      chk("basic_addr0", mem_img[0], 32'h22221111);
      chk("basic_addr1", mem_img[1], 32'h44443333);
      chk("basic_done_cnt", done_cnt - dn0, 1);

      // wrap
      src_q.push_back(16'hAAAA); src_q.push_back(16'hBBBB);
      src_q.push_back(16'hCCCC); src_q.push_back(16'hDDDD);
      do_start(7'd127, 8'd2);
      wait_idle(200, 0);
      chk("wrap_addr127", mem_img[127], 32'hBBBBAAAA);
      chk("wrap_addr0", mem_img[0], 32'hDDDDCCCC);

      // read priority while a write is pending
      rd0 = rd5_cnt; wr0 = wr_cnt;
      src_q.push_back(16'h0101); src_q.push_back(16'h0202);
      do_start(7'd10, 8'd1);
      n = 0;
      forever begin
         @(posedge clk);
         if (m_pending > 0 || n++ > 50) break;
      end
      #1;
      rd_req = 1'b1; rd_addr = 7'd5;
      repeat (3) @(posedge clk);
      #1;
      rd_req = 1'b0;
      wait_idle(200, 0);
      chk("arb_rd5_cnt", rd5_cnt - rd0, 3);
      chk("arb_wr_cnt", wr_cnt - wr0, 1);
      chk("arb_addr10", mem_img[10], 32'h02020101);

      // zero length
      wr0 = wr_cnt; dn0 = done_cnt;
      do_start(7'd3, 8'd0);
      wait_idle(50, 0);
      chk("zero_wr_cnt", wr_cnt - wr0, 0);
      chk("zero_done_cnt", done_cnt - dn0, 1);

      // start while busy is ignored
      wr0 = wr_cnt;
      do_start(7'd20, 8'd2);
      src_q.push_back(16'h2001); src_q.push_back(16'h2002);
      src_q.push_back(16'h2003); src_q.push_back(16'h2004);
      repeat (2) @(posedge clk);
      do_start(7'd50, 8'd1);
      wait_idle(200, 0);
      chk("busy_start_addr20", mem_img[20], 32'h20022001);
      chk("busy_start_addr21", mem_img[21], 32'h20042003);
      chk("busy_start_addr50", mem_img[50], 32'h0);
      chk("busy_start_wr_cnt", wr_cnt - wr0, 2);

      // backpressure 1,0,0,1
      vmode = 2;
      do_start(7'd30, 8'd1);
      vpat_q.push_back(1'b1); vpat_q.push_back(1'b0);
      vpat_q.push_back(1'b0); vpat_q.push_back(1'b1);
      src_q.push_back(16'h3101); src_q.push_back(16'h3202);
      wait_idle(200, 0);
      chk("bp_addr30", mem_img[30], 32'h32023101);
      vmode = 0;

      // full-depth load
      wr0 = wr_cnt;
      for (int i = 0; i < 256; i++) src_q.push_back(16'(i));
      do_start(7'd100, 8'd128);
      wait_idle(2000, 0);
      chk("full_wr_cnt", wr_cnt - wr0, 128);
      chk("full_first", mem_img[100], 32'h00010000);
      chk("full_last", mem_img[99], 32'h00FF00FE);

      // async reset while waiting for the high half
      dn0 = done_cnt;
      do_start(7'd40, 8'd1);
      src_q.push_back(16'h5555);
      n = 0;
      forever begin
         @(posedge clk);
         if (m_hs == 1 || n++ > 50) break;
      end
      #3;
      chk_en = 1'b0;
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1; chk_en = 1'b1;
      chk("midrst_no_done", done_cnt - dn0, 0);
      src_q.push_back(16'h6666); src_q.push_back(16'h7777);
      do_start(7'd40, 8'd1);
      wait_idle(200, 0);
      chk("post_rst_addr40", mem_img[40], 32'h77776666);

      // randomized loads with random reads, valid gaps and stray starts
      vmode = 1;
      for (int t = 0; t < 25; t++) begin
         sa = 7'($urandom);
         l  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
         for (int k = 0; k < 2 * l; k++) src_q.push_back(16'($urandom));
         do_start(sa, 8'(l));
         wait_idle(3000, 1);
      end
      chk("end_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
